regblock_cpuif_arbiter: RTL

REGBLOCK_CPUIF_ARBITER -- requirements
Module: regblock_cpuif_arbiter

---
 rtl/regblock_cpuif_arb_pkg.sv | 18 +
 rtl/cpuif_arb_id_fifo.sv | 51 +++++
 rtl/regblock_cpuif_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/regblock_cpuif_arb_pkg.sv
// Shared types for the regblock CPU-interface arbiter:
// response flags, ID FIFO entry and grant-index width.
package regblock_cpuif_arb_pkg;

  localparam int ARB_MAX_REQ = 8;
  localparam int ARB_IDX_W   = $clog2(ARB_MAX_REQ);

  typedef struct packed {
    logic is_wr;
    logic err;
  } arb_rsp_t;

  typedef struct packed {
    logic [ARB_IDX_W-1:0] id;
    logic                 is_wr;
  } id_entry_t;

endpackage

// File: rtl/cpuif_arb_id_fifo.sv
// In-order FIFO of requester IDs for accepted regblock transactions.
// Push and pop in the same cycle are legal even when full.
module cpuif_arb_id_fifo
  import regblock_cpuif_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  id_entry_t push_data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output id_entry_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  id_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop)  rd_ptr <= inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/regblock_cpuif_arbiter.sv
// Round-robin arbiter of N requesters onto one regblock CPU interface.
// Optional CPUIF_ARB_LOCK_EN adds s_lock to pin grant on the last winner.
module regblock_cpuif_arbiter
  import regblock_cpuif_arb_pkg::*;
#(
  parameter int N_REQ           = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                clk,
  input  logic                                rst,
`ifdef CPUIF_ARB_LOCK_EN
  input  logic [N_REQ-1:0]                    s_lock,
`endif
  input  logic [N_REQ-1:0]                    s_req,
  input  logic [N_REQ-1:0]                    s_req_is_wr,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]    s_addr,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]    s_wr_data,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]    s_wr_biten,
  output logic [N_REQ-1:0]                    s_req_ready,
  output logic [N_REQ-1:0]                    s_rsp_valid,
  output logic                                s_rsp_is_wr,
  output logic                                s_rsp_err,
  output logic [DATA_WIDTH-1:0]               s_rsp_rd_data,
  output logic                                cpuif_req,
  output logic                                cpuif_req_is_wr,
  output logic [ADDR_WIDTH-1:0]               cpuif_addr,
  output logic [DATA_WIDTH-1:0]               cpuif_wr_data,
  output logic [DATA_WIDTH-1:0]               cpuif_wr_biten,
  input  logic                                cpuif_req_stall_wr,
  input  logic                                cpuif_req_stall_rd,
  input  logic                                cpuif_rd_ack,
  input  logic                                cpuif_rd_err,
  input  logic [DATA_WIDTH-1:0]               cpuif_rd_data,
  input  logic                                cpuif_wr_ack,
  input  logic                                cpuif_wr_err,
  output logic                                protocol_err
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] last_acc;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] hold_idx;
  logic [IDX_W-1:0] cand;
  logic             hold_q;
  logic             stall;
  logic             accept;
  logic             any_ack;
  logic             dual_ack;
  logic             pop;
  logic             blocked;
  logic             fifo_full;
  logic             fifo_empty;
  id_entry_t        head;
  id_entry_t        push_entry;
  arb_rsp_t         rsp;

  // Last write wins, so the nearest requester after last_acc is chosen.
  always_comb begin
    rr_idx = last_acc;
    cand   = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last_acc) + i) % N_REQ);
      if (s_req[cand]) rr_idx = cand;
    end
  end

  always_comb begin
    grant = rr_idx;
    if (hold_q && s_req[hold_idx]) grant = hold_idx;
`ifdef CPUIF_ARB_LOCK_EN
    if (s_lock[last_acc]) grant = last_acc;
`endif
  end

  assign any_ack  = cpuif_rd_ack | cpuif_wr_ack;
  assign dual_ack = cpuif_rd_ack & cpuif_wr_ack;
  assign pop      = any_ack & ~fifo_empty & ~rst;
  assign blocked  = fifo_full & ~pop;

  assign stall  = s_req_is_wr[grant] ? cpuif_req_stall_wr
                                     : cpuif_req_stall_rd;
  assign cpuif_req = s_req[grant] & ~blocked & ~rst;
  assign accept    = cpuif_req & ~stall;

  assign s_req_ready     = accept ? (N_REQ'(1) << grant) : '0;
  assign cpuif_req_is_wr = ~rst & s_req_is_wr[grant];
  assign cpuif_addr      = rst ? '0 : s_addr[grant];
  assign cpuif_wr_data   = rst ? '0 : s_wr_data[grant];
  assign cpuif_wr_biten  = rst ? '0 : s_wr_biten[grant];

  // On a double ack, trust the head entry's recorded direction.
  assign rsp.is_wr = dual_ack ? head.is_wr : cpuif_wr_ack;
  assign rsp.err   = rsp.is_wr ? cpuif_wr_err : cpuif_rd_err;

  assign s_rsp_valid   = pop ? (N_REQ'(1) << head.id) : '0;
  assign s_rsp_is_wr   = pop & rsp.is_wr;
  assign s_rsp_err     = pop & rsp.err;
  assign s_rsp_rd_data = (pop && !rsp.is_wr) ? cpuif_rd_data : '0;

  assign push_entry.id    = ARB_IDX_W'(grant);
  assign push_entry.is_wr = s_req_is_wr[grant];

  always_ff @(posedge clk) begin
    if (rst) begin
      last_acc     <= IDX_W'(N_REQ - 1);
      hold_q       <= 1'b0;
      hold_idx     <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (accept) last_acc <= grant;
      hold_q   <= s_req[grant] & ~accept;
      hold_idx <= grant;
      if ((any_ack && fifo_empty) || dual_ack) protocol_err <= 1'b1;
    end
  end

  cpuif_arb_id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_data(push_entry),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

endmodule
